// File: rtl/pkg_ram.sv
// Shared RAM port definitions: op encodings, field widths and boot sequencing states.
package pkg_ram;

  localparam int unsigned RAM_ADDRW = 16;
  localparam int unsigned RAM_SIZEW = 2;
  localparam int unsigned RAM_OPW   = 2;
  localparam int unsigned RAM_QUAD  = 32;

  localparam logic [RAM_OPW-1:0] RAM_NOP   = 2'd0;
  localparam logic [RAM_OPW-1:0] RAM_LOAD  = 2'd1;
  localparam logic [RAM_OPW-1:0] RAM_STORE = 2'd2;

  typedef enum logic [1:0] {
    BOOT_LOAD  = 2'd0,
    BOOT_DRAIN = 2'd1,
    BOOT_RUN   = 2'd2,
    BOOT_HOLD  = 2'd3
  } boot_state_t;

  typedef struct packed {
    logic [RAM_OPW-1:0]   op;
    logic [RAM_ADDRW-1:0] addr;
    logic [RAM_SIZEW-1:0] size;
    logic [RAM_QUAD-1:0]  data;
  } ram_req_t;

endpackage

// File: rtl/ram_port_mux.sv
// Registered two-master RAM port mux; drives an all-zero NOP request when disabled.
module ram_port_mux
  import pkg_ram::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en_i,
  input  logic     sel_i,
  input  ram_req_t a_i,
  input  ram_req_t b_i,
  output ram_req_t q_o
);

  ram_req_t q_q;
  ram_req_t q_d;

  always_comb begin
    q_d = '0;
    if (en_i) begin
      q_d = sel_i ? b_i : a_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ram_boot_arbiter.sv
// Boot sequencer owning the single RAM port: loader first, then a drain window,
// then the CPU; a reload request parks the CPU in reset and re-enters loading.
module ram_boot_arbiter
  import pkg_ram::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNTW         = pkg_ram::RAM_ADDRW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RAM_OPW-1:0]   ld_op,
  input  logic [RAM_ADDRW-1:0] ld_addr,
  input  logic [RAM_SIZEW-1:0] ld_size,
  input  logic [RAM_QUAD-1:0]  ld_data,
  input  logic                 ld_done,
  input  logic [RAM_OPW-1:0]   cpu_op,
  input  logic [RAM_ADDRW-1:0] cpu_addr,
  input  logic [RAM_SIZEW-1:0] cpu_size,
  input  logic [RAM_QUAD-1:0]  cpu_data,
  input  logic                 reload,
  output logic [RAM_OPW-1:0]   ram_op,
  output logic [RAM_ADDRW-1:0] ram_addr,
  output logic [RAM_SIZEW-1:0] ram_size,
  output logic [RAM_QUAD-1:0]  ram_data,
  output logic                 cpu_rst,
  output logic                 cpu_stall,
  output logic [CNTW-1:0]      loaded_bytes,
  output logic                 err_late,
  output logic [1:0]           state
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_RELOAD = DCW'(DRAIN_CYCLES - 1);

  boot_state_t     state_q, state_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [CNTW-1:0] loaded_q, loaded_d;
  logic            err_q, err_d;
  logic            mux_en, mux_sel;

  ram_req_t ld_req, cpu_req, ram_req;

  assign ld_req  = '{op: ld_op, addr: ld_addr, size: ld_size, data: ld_data};
  assign cpu_req = '{op: cpu_op, addr: cpu_addr, size: cpu_size, data: cpu_data};

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    mux_en   = 1'b0;
    mux_sel  = 1'b0;

    unique case (state_q)
      BOOT_LOAD: begin
        mux_en = 1'b1;
        if (ld_op == RAM_STORE && loaded_q != '1) begin
          loaded_d = loaded_q + CNTW'(1);
        end
        if (ld_done) begin
          state_d = BOOT_DRAIN;
          drain_d = DRAIN_RELOAD;
        end
      end
      BOOT_DRAIN: begin
        mux_en = 1'b1;
        if (ld_op == RAM_STORE && loaded_q != '1) begin
          loaded_d = loaded_q + CNTW'(1);
        end
        // A late store restarts the idle window so it fully drains before handover.
        if (!ld_done) begin
          state_d = BOOT_LOAD;
        end else if (ld_op != RAM_NOP) begin
          drain_d = DRAIN_RELOAD;
        end else if (drain_q == '0) begin
          state_d = BOOT_RUN;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      BOOT_RUN: begin
        mux_en  = 1'b1;
        mux_sel = 1'b1;
        if (ld_op != RAM_NOP) begin
          err_d = 1'b1;
        end
        if (reload) begin
          state_d = BOOT_HOLD;
        end
      end
      BOOT_HOLD: begin
        if (!ld_done) begin
          state_d  = BOOT_LOAD;
          loaded_d = '0;
        end
      end
      default: state_d = BOOT_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT_LOAD;
      drain_q  <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  ram_port_mux u_mux (
    .clk   (clk),
    .rst   (rst),
    .en_i  (mux_en),
    .sel_i (mux_sel),
    .a_i   (ld_req),
    .b_i   (cpu_req),
    .q_o   (ram_req)
  );

  assign ram_op       = ram_req.op;
  assign ram_addr     = ram_req.addr;
  assign ram_size     = ram_req.size;
  assign ram_data     = ram_req.data;
  assign cpu_rst      = (state_q != BOOT_RUN);
  assign cpu_stall    = (state_q != BOOT_RUN);
  assign loaded_bytes = loaded_q;
  assign err_late     = err_q;
  assign state        = state_q;

endmodule

// File: doc/ram_boot_arbiter.md
Name: ram_boot_arbiter

Overview:
- Owns the single RAM port and sequences system boot.
- After reset, the hex loader owns the port and the CPU is held in reset.
- When loading completes and the last store has drained, the port is handed to the CPU and CPU reset is released.
- A reload request takes the port back, re-holds the CPU and re-enters loading.

Parameters:
- DRAIN_CYCLES, 4: idle cycles required after loader done before handover; must be ≥1.
- CNTW, pkg_ram::RAM_ADDRW+1: width of the loaded-byte counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ld_op  in  RAM_OPW  loader RAM op (RAM_NOP/RAM_STORE), single-cycle pulses.
- ld_addr  in  RAM_ADDRW  loader address.
- ld_size  in  RAM_SIZEW  loader access size.
- ld_data  in  RAM_QUAD  loader store data.
- ld_done  in  1  loader end-of-image level.
- cpu_op  in  RAM_OPW  CPU RAM op.
- cpu_addr  in  RAM_ADDRW  CPU address.
- cpu_size  in  RAM_SIZEW  CPU access size.
- cpu_data  in  RAM_QUAD  CPU store data.
- reload  in  1  single-cycle request to re-enter boot.
- ram_op  out  RAM_OPW  RAM op to memory.
- ram_addr  out  RAM_ADDRW  RAM address.
- ram_size  out  RAM_SIZEW  RAM access size.
- ram_data  out  RAM_QUAD  RAM store data.
- cpu_rst  out  1  CPU reset, active-high.
- cpu_stall  out  1  CPU op not accepted this cycle.
- loaded_bytes  out  CNTW  RAM_STORE ops forwarded since the last entry to LOAD.
- err_late  out  1  sticky: loader op arrived while the CPU owned the port.
- state  out  2  current boot state, for debug/LED.

Behaviour:
- Clock/reset: clock clk; reset rst, synchronous, active-high.
- Reset values: state=LOAD, ram_op=RAM_NOP, ram_addr/ram_size/ram_data=0, cpu_rst=1, cpu_stall=1, loaded_bytes=0, err_late=0, drain counter=0.
- Registered outputs: all ram_* outputs are registered. An op selected in cycle N appears on ram_* in cycle N+1. Exactly one master's op is forwarded per cycle, otherwise RAM_NOP.
- States: LOAD=0, DRAIN=1, RUN=2, HOLD=3.
- LOAD:
  - Forward ld_* to ram_*.
  - Each forwarded RAM_STORE increments loaded_bytes, saturating at all-ones.
  - When ld_done=1, go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
  - If ld_done=1 and ld_op=RAM_STORE in the same cycle, the store is forwarded and counted, then the transition to DRAIN happens.
- DRAIN:
  - Keep forwarding ld_*.
  - A non-NOP ld_op reloads the counter to DRAIN_CYCLES-1 and is counted.
  - If the counter is 0 and ld_op=RAM_NOP, go to RUN.
  - If ld_done drops to 0, return to LOAD without clearing the count.
- RUN:
  - cpu_rst=0 (registered, deasserts on the first RUN cycle) and cpu_stall=0.
  - Forward cpu_* to ram_*.
  - A non-NOP ld_op is dropped and sets err_late; err_late is cleared only by rst.
  - reload=1 moves to HOLD; the CPU op in that same cycle is still forwarded.
- HOLD:
  - cpu_rst=1, cpu_stall=1, ram_op=RAM_NOP.
  - Loader ops in HOLD are dropped silently, without setting err_late.
  - Stay in HOLD until ld_done=0, then go to LOAD and clear loaded_bytes to 0.
- Outside RUN: cpu_stall=1 and CPU ops are never forwarded, even when cpu_op≠NOP.
- reload in LOAD, DRAIN or HOLD is ignored.
- Reset mid-operation: rst in any state returns to the reset values next cycle. A pending registered op is replaced by RAM_NOP.
- Widths: loaded_bytes is CNTW bits, saturating with no wrap. The drain counter is $clog2(DRAIN_CYCLES+1) bits.

Decomposition:
- pkg_ram (shared) gains:
  - typedef enum logic[1:0] boot_state_t {BOOT_LOAD, BOOT_DRAIN, BOOT_RUN, BOOT_HOLD}.
  - RAM_OPW and RAM_SIZEW constants, if not already present.
  - Existing RAM_NOP/RAM_STORE/RAM_LOAD and width constants are reused.
- One sub-module: ram_port_mux, which registers the port mux between two masters (select input, NOP otherwise). The FSM, counters and error flag stay in ram_boot_arbiter.

Test Plan:
- Reset, then 3 loader stores to addr 0,1,2 with data 0xDE,0xAD,0xBE, then ld_done=1 → ram_* shows each store one cycle later; loaded_bytes=3; state DRAIN for 4 cycles, then RUN; cpu_rst falls on the first RUN cycle.
- ld_done=1 in the same cycle as a store to addr 5 → store forwarded, loaded_bytes+1, state DRAIN next cycle.
- Store arrives at DRAIN counter=1 → counter reloads; RUN is reached DRAIN_CYCLES cycles after that store.
- In RUN, CPU RAM_LOAD at addr 0x10 plus a simultaneous loader store → ram_op=LOAD at 0x10; loader op dropped; err_late=1 and stays 1.
- In RUN, reload pulse with a CPU store at 0x20 → store forwarded; HOLD next cycle with cpu_rst=1; with ld_done held 1, stay in HOLD; drop ld_done → LOAD with loaded_bytes=0.
- rst asserted in DRAIN with a store in flight → next cycle ram_op=NOP, state LOAD, cpu_rst=1, loaded_bytes=0, err_late=0.
